// File: rtl/riscv_pipe_pkg.sv
// Shared encodings and helpers for the five-stage RISC-V pipeline control path.
// Holds the hazard FSM state encoding, forwarding selects and per-action control bundle.
package riscv_pipe_pkg;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [1:0] {
        HCU_RUN    = 2'd0,
        HCU_STALL  = 2'd1,
        HCU_FLUSH  = 2'd2,
        HCU_FREEZE = 2'd3
    } hcu_state_t;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic pipe_freeze;
    } hcu_ctrl_t;

    // Stage-register controls applied for a given cycle action.
    function automatic hcu_ctrl_t ctrl_for(input hcu_state_t action);
        hcu_ctrl_t c;
        c = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
              idex_flush: 1'b0, pipe_freeze: 1'b0};
        case (action)
            HCU_FREEZE: begin
                c.pc_write    = 1'b0;
                c.ifid_write  = 1'b0;
                c.pipe_freeze = 1'b1;
            end
            HCU_FLUSH: begin
                c.ifid_flush = 1'b1;
                c.idex_flush = 1'b1;
            end
            HCU_STALL: begin
                c.pc_write   = 1'b0;
                c.ifid_write = 1'b0;
                c.idex_flush = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    // Controls held on the stage registers while the core is in reset.
    function automatic hcu_ctrl_t ctrl_reset();
        return '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                 idex_flush: 1'b1, pipe_freeze: 1'b0};
    endfunction

    // A later-stage producer matches an EX source only if it writes a real register.
    function automatic logic producer_hit(input logic we, input reg_idx_t rd,
                                          input reg_idx_t src);
        return we && (rd != 5'd0) && (rd == src);
    endfunction

    function automatic fwd_sel_t fwd_pick(input logic exmem_we, input reg_idx_t exmem_rd,
                                          input logic memwb_we, input reg_idx_t memwb_rd,
                                          input reg_idx_t src);
        if (producer_hit(exmem_we, exmem_rd, src))
            return FWD_EXMEM;
        else if (producer_hit(memwb_we, memwb_rd, src))
            return FWD_MEMWB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Combinational EX-stage operand forwarding; the youngest producer (EX/MEM) wins.
module forwarding_unit
    import riscv_pipe_pkg::*;
(
    input  logic       exmem_reg_write,
    input  logic [4:0] exmem_rd,
    input  logic       memwb_reg_write,
    input  logic [4:0] memwb_rd,
    input  logic [4:0] idex_rs1,
    input  logic [4:0] idex_rs2,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b
);

    fwd_sel_t sel_a;
    fwd_sel_t sel_b;

    always_comb begin
        sel_a = fwd_pick(exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd, idex_rs1);
        sel_b = fwd_pick(exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd, idex_rs2);
    end

    assign forward_a = sel_a;
    assign forward_b = sel_b;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard/control: picks FREEZE > FLUSH > STALL > RUN each cycle, drives the
// stage-register controls and forwarding, and records the action for CPI counters.
module hazard_control_unit
    import riscv_pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       idex_rs1,
    input  logic [4:0]       idex_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_mem_read,
    input  logic             ex_branch_taken,
    input  logic [4:0]       exmem_rd,
    input  logic [4:0]       memwb_rd,
    input  logic             exmem_reg_write,
    input  logic             memwb_reg_write,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [1:0]       hcu_state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] freeze_count
);

    logic       load_use;
    hcu_state_t action;
    hcu_state_t state_q;
    hcu_ctrl_t  ctrl;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    forwarding_unit u_forwarding (
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .idex_rs1        (idex_rs1),
        .idex_rs2        (idex_rs2),
        .forward_a       (fwd_a_raw),
        .forward_b       (fwd_b_raw)
    );

    always_comb begin
        load_use = idex_mem_read && (idex_rd != 5'd0) &&
                   ((id_rs1_used && (id_rs1 == idex_rd)) ||
                    (id_rs2_used && (id_rs2 == idex_rd)));
    end

    // A taken branch stays parked in EX during a freeze and is acted on afterwards.
    always_comb begin
        if (mem_busy)
            action = HCU_FREEZE;
        else if (ex_branch_taken)
            action = HCU_FLUSH;
        else if (load_use)
            action = HCU_STALL;
        else
            action = HCU_RUN;
    end

    always_comb begin
        ctrl = reset ? ctrl_reset() : ctrl_for(action);
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign pipe_freeze = ctrl.pipe_freeze;
    assign forward_a   = reset ? FWD_REG : fwd_a_raw;
    assign forward_b   = reset ? FWD_REG : fwd_b_raw;
    assign hcu_state   = state_q;

    // Counters saturate so long CPI runs never alias back to small values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HCU_RUN;
            stall_count  <= '0;
            flush_count  <= '0;
            freeze_count <= '0;
        end else begin
            state_q <= action;
            if (action == HCU_STALL && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
            if (action == HCU_FLUSH && flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);
            if (action == HCU_FREEZE && freeze_count != '1)
                freeze_count <= freeze_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard and control block for the five-stage RISC-V core. It consumes the decoded fields leaving IF/ID and the control outputs of ID/EX, EX/MEM and MEM/WB. It drives the write-enable, flush and freeze inputs of the stage registers, plus the EX-stage forwarding selects. A small registered FSM records the action applied each cycle and feeds saturating event counters used for CPI measurement.

## Interface
Parameters:
- CNT_W, 32, width of each event counter

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID (from IF/ID)
- id_rs1_used, id_rs2_used  in  1 each  instruction in ID actually reads rs1/rs2
- idex_rs1, idex_rs2  in  5 each  rs1_out/rs2_out of ID/EX
- idex_rd  in  5  rd_out of ID/EX
- idex_mem_read  in  1  mem_read_out of ID/EX
- ex_branch_taken  in  1  beq in EX evaluated taken (beq_instruction_out && zero)
- exmem_rd, memwb_rd  in  5 each  destination registers in MEM and WB
- exmem_reg_write, memwb_reg_write  in  1 each  write enables in MEM and WB
- mem_busy  in  1  data memory not ready; pipeline must freeze
- pc_write  out  1  PC register load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_flush  out  1  ID/EX clear to bubble (all control bits 0)
- pipe_freeze  out  1  ID/EX, EX/MEM, MEM/WB hold current contents
- forward_a, forward_b  out  2 each  ALU operand select: 00 register file, 10 EX/MEM, 01 MEM/WB
- hcu_state  out  2  registered FSM state
- stall_count, flush_count, freeze_count  out  CNT_W each  event counters

## Operation
- Cycle action is chosen combinationally. Priority: FREEZE > FLUSH > STALL > RUN.
- FREEZE, when mem_busy=1:
  - pc_write=0, ifid_write=0, pipe_freeze=1, no flushes.
  - A taken branch is held in EX and acted on in the first cycle after mem_busy falls.
- FLUSH, when ex_branch_taken=1:
  - pc_write=1 (EX supplies the target), ifid_write=1, ifid_flush=1, idex_flush=1.
  - A load-use hazard in the same cycle is ignored, because its instruction is discarded.
- STALL (load-use), when idex_mem_read=1, idex_rd≠0, and either (id_rs1_used and id_rs1==idex_rd) or (id_rs2_used and id_rs2==idex_rd):
  - pc_write=0, ifid_write=0, idex_flush=1.
- RUN: pc_write=1, ifid_write=1, all flush and freeze outputs 0.
- Forwarding is combinational and independent of the action. For operand a:
  - 10 if exmem_reg_write and exmem_rd≠0 and exmem_rd==idex_rs1.
  - Otherwise 01 if memwb_reg_write and memwb_rd≠0 and memwb_rd==idex_rs1.
  - Otherwise 00. EX/MEM always wins.
  - forward_b uses the same rule with idex_rs2.
- FSM states: RUN=0, STALL=1, FLUSH=2, FREEZE=3. On each clock edge, hcu_state takes the action applied in that cycle, so all transitions between any two states are legal.
- Counters: each counter increments by 1 on every clock edge whose applied action is STALL, FLUSH or FREEZE respectively. Counters saturate at all-ones and never wrap.

## Timing
- While reset=1:
  - pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pipe_freeze=0, forward_a/b=00.
  - At the clock edge: hcu_state←RUN and all counters←0.
- The first cycle after reset is released behaves as RUN unless inputs dictate otherwise.
- Control outputs have zero latency: they are valid in the same cycle as their inputs and take effect at the next edge.
- hcu_state and the counters lag the applied action by one cycle.
- A load-use stall lasts exactly one cycle. After the bubble, idex_mem_read=0, so the hazard clears without any FSM help.
- Reset mid-freeze or mid-stall: the action is abandoned immediately and counters clear; there is no residual state.

## Structure
- Shared package riscv_pipe_pkg holds:
  - the hcu_state encoding (HCU_RUN, HCU_STALL, HCU_FLUSH, HCU_FREEZE);
  - the forwarding encodings FWD_REG=00, FWD_EXMEM=10, FWD_MEMWB=01.
- Sub-module forwarding_unit holds the purely combinational forward_a/forward_b logic.
- hazard_control_unit contains the priority logic, the state register and the counters.

## Test plan
- Load-use: idex_mem_read=1, idex_rd=5, id_rs1=5, id_rs1_used=1 -> pc_write=0, ifid_write=0, idex_flush=1 for one cycle; next cycle hcu_state=1 and stall_count=1.
- x0 immunity: the same hazard with idex_rd=0 -> RUN outputs; a forward check with exmem_rd=0 and idex_rs1=0 -> forward_a=00.
- Branch over hazard: ex_branch_taken=1 together with a load-use match -> ifid_flush=1, idex_flush=1, pc_write=1; flush_count=1 and stall_count=0.
- Freeze: mem_busy high for 3 cycles with ex_branch_taken=1 -> pipe_freeze=1 for 3 cycles, then FLUSH for 1 cycle; freeze_count=3 and flush_count=1.
- Forward priority: exmem_rd=memwb_rd=idex_rs2=7, both write enables set -> forward_b=10; with exmem_reg_write=0 -> forward_b=01.
- Saturation and reset: with CNT_W=4, 20 stall cycles -> stall_count=15; reset asserted mid-stream -> all counters 0 and hcu_state=0 after the edge.
